// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the RV32I pipeline controllers.
package cpu_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_MEMWAIT = 2'd1,
      ST_HALT    = 2'd2,
      ST_ERR     = 2'd3
   } ctrl_state_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [31:0] INSTR_NOP = 32'h00000013;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Load-use detector: flags an ID instruction that reads the rd of a load
// currently in EX, which forwarding cannot cover.
module load_use_detect
   import cpu_ctrl_pkg::*;
(
   input  logic [31:0] instr_id,
   input  logic [31:0] instr_ex,
   input  logic        mem_read_ex,
   output logic        load_use
);

   logic [6:0] opc_id;
   logic [4:0] rd_ex;
   logic       uses_rs1;
   logic       uses_rs2;
   logic       unused_bits;

   assign opc_id = instr_id[6:0];
   assign rd_ex  = instr_ex[11:7];

   // Only these opcodes carry no rs1 field; only these three read rs2.
   assign uses_rs1 = !((opc_id == OPC_LUI) || (opc_id == OPC_AUIPC) || (opc_id == OPC_JAL));
   assign uses_rs2 = (opc_id == OPC_OP) || (opc_id == OPC_STORE) || (opc_id == OPC_BRANCH);

   assign load_use = mem_read_ex && (rd_ex != 5'd0) &&
                     ((uses_rs1 && (rd_ex == instr_id[19:15])) ||
                      (uses_rs2 && (rd_ex == instr_id[24:20])));

   assign unused_bits = ^{instr_id[31:25], instr_id[14:7], instr_ex[31:12], instr_ex[6:0]};

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller: owns every PC / pipeline-register
// advance decision for the 5-stage core.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal flow; hazards resolved per cycle by priority
// MEMWAIT | data memory is holding MEM; watchdog counting
// HALT    | ECALL/EBREAK retired; everything frozen until resume
// ERR     | watchdog expired; frozen until reset
module hazard_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] Instruction_IFID_IDEX,
   input  logic [31:0] Instruction_IDEX_out,
   input  logic        MemRead_IDEX_out,
   input  logic        branch_taken_EX,
   input  logic        imem_ready,
   input  logic        dmem_req_MEM,
   input  logic        dmem_ack,
   input  logic        halt_MEM,
   input  logic        resume,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        idex_en,
   output logic        exmem_en,
   output logic        memwb_en,
   output logic        ifid_flush,
   output logic        idex_bubble,
   output logic        exmem_bubble,
   output logic        memwb_bubble,
   output logic        halted,
   output logic        mem_err,
   output logic [31:0] stall_count
);

   localparam int unsigned WCW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WCW-1:0] WC_LAST = WCW'(MEM_TIMEOUT - 1);

   ctrl_state_e    state_q, state_d;
   logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
   logic [31:0]    stall_count_q, stall_count_d;
   logic           load_use;
   logic           mem_freeze;
   logic           stall_hit;

   load_use_detect u_lud (
      .instr_id    (Instruction_IFID_IDEX),
      .instr_ex    (Instruction_IDEX_out),
      .mem_read_ex (MemRead_IDEX_out),
      .load_use    (load_use)
   );

   assign mem_freeze  = dmem_req_MEM && !dmem_ack;
   assign stall_count = stall_count_q;

   // Control outputs: prioritised hazard rules; reset forces a fully frozen, bubbled pipe.
   always_comb begin
      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      idex_en      = 1'b1;
      exmem_en     = 1'b1;
      memwb_en     = 1'b1;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      exmem_bubble = 1'b0;
      memwb_bubble = 1'b0;
      halted       = 1'b0;
      mem_err      = 1'b0;
      stall_hit    = 1'b0;
      if (!rst_n) begin
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         idex_en      = 1'b0;
         exmem_en     = 1'b0;
         memwb_en     = 1'b0;
         ifid_flush   = 1'b1;
         idex_bubble  = 1'b1;
         exmem_bubble = 1'b1;
         memwb_bubble = 1'b1;
      end else begin
         case (state_q)
            ST_RUN, ST_MEMWAIT: begin
               if (mem_freeze) begin
                  pc_en        = 1'b0;
                  ifid_en      = 1'b0;
                  idex_en      = 1'b0;
                  exmem_en     = 1'b0;
                  memwb_bubble = 1'b1;
                  stall_hit    = 1'b1;
               end else if (halt_MEM) begin
                  // Halt stalls are not counted; the branch (if any) waits in EX.
                  pc_en        = 1'b0;
                  ifid_en      = 1'b0;
                  idex_en      = 1'b0;
                  exmem_bubble = 1'b1;
               end else if (branch_taken_EX) begin
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
               end else if (load_use) begin
                  pc_en       = 1'b0;
                  ifid_en     = 1'b0;
                  idex_bubble = 1'b1;
                  stall_hit   = 1'b1;
               end else if (!imem_ready) begin
                  pc_en      = 1'b0;
                  ifid_flush = 1'b1;
                  stall_hit  = 1'b1;
               end
            end
            default: begin
               pc_en        = 1'b0;
               ifid_en      = 1'b0;
               idex_en      = 1'b0;
               exmem_en     = 1'b0;
               memwb_en     = 1'b0;
               memwb_bubble = 1'b1;
               halted       = 1'b1;
               mem_err      = (state_q == ST_ERR);
            end
         endcase
      end
   end

   // Next state, watchdog and stall counter.
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = '0;
      stall_count_d = stall_count_q;
      case (state_q)
         ST_RUN, ST_MEMWAIT: begin
            if (stall_hit && (stall_count_q != 32'hFFFF_FFFF)) begin
               stall_count_d = stall_count_q + 32'd1;
            end
            if (mem_freeze) begin
               if (wait_cnt_q == WC_LAST) begin
                  state_d = ST_ERR;
               end else begin
                  state_d    = ST_MEMWAIT;
                  wait_cnt_d = wait_cnt_q + 1'b1;
               end
            end else if (halt_MEM) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_HALT: begin
            if (resume) state_d = ST_RUN;
         end
         default: state_d = ST_ERR;
      endcase
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         wait_cnt_q    <= '0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         stall_count_q <= stall_count_d;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic
// against a rule-level reference model.
module tb_hazard_ctrl;

   localparam int TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] Instruction_IFID_IDEX;
   logic [31:0] Instruction_IDEX_out;
   logic        MemRead_IDEX_out;
   logic        branch_taken_EX;
   logic        imem_ready;
   logic        dmem_req_MEM;
   logic        dmem_ack;
   logic        halt_MEM;
   logic        resume;
   logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic        ifid_flush, idex_bubble, exmem_bubble, memwb_bubble;
   logic        halted, mem_err;
   logic [31:0] stall_count;

   int checks = 0;
   int errors = 0;

   // model state
   bit          m_halt;
   bit          m_err;
   int          m_frz;
   logic [31:0] m_stall;

   hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .Instruction_IFID_IDEX (Instruction_IFID_IDEX),
      .Instruction_IDEX_out  (Instruction_IDEX_out),
      .MemRead_IDEX_out      (MemRead_IDEX_out),
      .branch_taken_EX       (branch_taken_EX),
      .imem_ready            (imem_ready),
      .dmem_req_MEM          (dmem_req_MEM),
      .dmem_ack              (dmem_ack),
      .halt_MEM              (halt_MEM),
      .resume                (resume),
      .pc_en                 (pc_en),
      .ifid_en               (ifid_en),
      .idex_en               (idex_en),
      .exmem_en              (exmem_en),
      .memwb_en              (memwb_en),
      .ifid_flush            (ifid_flush),
      .idex_bubble           (idex_bubble),
      .exmem_bubble          (exmem_bubble),
      .memwb_bubble          (memwb_bubble),
      .halted                (halted),
      .mem_err               (mem_err),
      .stall_count           (stall_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit m_load_use(input logic [31:0] id, input logic [31:0] ex, input bit mr);
      logic [6:0] op;
      logic [4:0] rd;
      bit u1, u2;
      op = id[6:0];
      rd = ex[11:7];
      u1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
      u2 = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
      return mr && (rd != 5'd0) && ((u1 && rd == id[19:15]) || (u2 && rd == id[24:20]));
   endfunction

   // Expected {pc,ifid,idex,exmem,memwb, ifid_flush,idex_b,exmem_b,memwb_b}
   task automatic m_ctrl(output logic [8:0] c, output bit stall_inc);
      stall_inc = 0;
      if (m_halt || m_err)                      c = 9'b00000_0001;
      else if (dmem_req_MEM && !dmem_ack)  begin c = 9'b00001_0001; stall_inc = 1; end
      else if (halt_MEM)                        c = 9'b00011_0010;
      else if (branch_taken_EX)                 c = 9'b11111_1100;
      else if (m_load_use(Instruction_IFID_IDEX, Instruction_IDEX_out, MemRead_IDEX_out)) begin
         c = 9'b00111_0100; stall_inc = 1;
      end
      else if (!imem_ready)                begin c = 9'b01111_1000; stall_inc = 1; end
      else                                      c = 9'b11111_0000;
   endtask

   task automatic check_outputs(input string tag);
      logic [8:0] c;
      bit si;
      m_ctrl(c, si);
      chk({tag, "/ctrl"}, 64'({pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                               ifid_flush, idex_bubble, exmem_bubble, memwb_bubble}), 64'(c));
      chk({tag, "/halted"}, 64'(halted), 64'(m_halt || m_err));
      chk({tag, "/mem_err"}, 64'(mem_err), 64'(m_err));
      chk({tag, "/stall_count"}, 64'(stall_count), 64'(m_stall));
   endtask

   task automatic model_clk();
      logic [8:0] c;
      bit si;
      m_ctrl(c, si);
      if (m_err) begin
      end else if (m_halt) begin
         if (resume) m_halt = 0;
      end else begin
         if (si && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
         if (dmem_req_MEM && !dmem_ack) begin
            if (m_frz + 1 >= TIMEOUT) begin m_err = 1; m_frz = 0; end
            else m_frz = m_frz + 1;
         end else begin
            m_frz = 0;
            if (halt_MEM) m_halt = 1;
         end
      end
   endtask

   // Inputs are already driven (at a negedge); check, then clock once.
   task automatic step(input string tag);
      #1;
      check_outputs(tag);
      @(posedge clk);
      model_clk();
      @(negedge clk);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      m_halt = 0; m_err = 0; m_frz = 0; m_stall = '0;
      chk({tag, "/rst_ctrl"}, 64'({pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                                   ifid_flush, idex_bubble, exmem_bubble, memwb_bubble}),
          64'(9'b00000_1111));
      chk({tag, "/rst_halted"}, 64'(halted), 64'd0);
      chk({tag, "/rst_mem_err"}, 64'(mem_err), 64'd0);
      chk({tag, "/rst_stall"}, 64'(stall_count), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic idle();
      Instruction_IFID_IDEX = 32'h00000013;
      Instruction_IDEX_out  = 32'h00000013;
      MemRead_IDEX_out = 0; branch_taken_EX = 0; imem_ready = 1;
      dmem_req_MEM = 0; dmem_ack = 0; halt_MEM = 0; resume = 0;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0] ops [8];
      logic [31:0] v;
      ops = '{7'b0000011, 7'b0010011, 7'b0110011, 7'b0100011,
              7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
      v = $urandom;
      v[6:0]   = ops[$urandom_range(0, 7)];
      v[11:7]  = 5'($urandom_range(0, 3));
      v[19:15] = 5'($urandom_range(0, 3));
      v[24:20] = 5'($urandom_range(0, 3));
      return v;
   endfunction

   initial begin
      idle();
      do_reset("init");
      step("idle");

      // load-use: lw x5 in EX, add x6,x5,x1 in ID
      Instruction_IDEX_out  = {12'h000, 5'd2, 3'b010, 5'd5, 7'b0000011};
      MemRead_IDEX_out      = 1;
      Instruction_IFID_IDEX = {7'd0, 5'd1, 5'd5, 3'd0, 5'd6, 7'b0110011};
      step("lu_stall");
      MemRead_IDEX_out = 0;
      step("lu_release");
      MemRead_IDEX_out      = 1;
      Instruction_IFID_IDEX = {20'd1, 5'd5, 7'b0110111};
      step("lu_lui");
      Instruction_IFID_IDEX = {7'd0, 5'd1, 5'd5, 3'd0, 5'd6, 7'b0110011};
      branch_taken_EX = 1;
      imem_ready      = 0;
      step("br_over_lu");
      idle();

      // memory wait, ack after 3 freeze cycles
      dmem_req_MEM = 1;
      repeat (3) step("mw_freeze");
      dmem_ack = 1;
      step("mw_ack");
      idle();
      step("mw_after");

      // ack in the last tolerated cycle
      dmem_req_MEM = 1;
      repeat (TIMEOUT - 1) step("wd_edge_freeze");
      dmem_ack = 1;
      step("wd_edge_ack");
      idle();
      step("wd_edge_after");

      // halt with simultaneous branch, then resume
      halt_MEM = 1; branch_taken_EX = 1;
      step("halt_enter");
      halt_MEM = 0;
      step("halted");
      resume = 1;
      step("resume");
      resume = 0; branch_taken_EX = 0;
      step("after_resume");
      resume = 1;
      step("resume_ignored");
      idle();

      // watchdog
      dmem_req_MEM = 1;
      repeat (TIMEOUT + 3) step("watchdog");
      idle();
      step("err_sticky");
      #2;
      do_reset("err_reset");

      // async reset mid-MEMWAIT
      dmem_req_MEM = 1;
      repeat (2) step("pre_rst_mw");
      #2;
      do_reset("mw_async_reset");
      idle();
      step("post_rst");

      // random traffic
      for (int i = 0; i < 500; i++) begin
         Instruction_IFID_IDEX = rand_instr();
         Instruction_IDEX_out  = rand_instr();
         MemRead_IDEX_out = 1'($urandom_range(0, 1));
         branch_taken_EX  = ($urandom_range(0, 4) == 0);
         imem_ready       = ($urandom_range(0, 4) != 0);
         dmem_req_MEM     = ($urandom_range(0, 3) == 0) || (m_frz != 0 && $urandom_range(0, 1) == 0);
         dmem_ack         = ($urandom_range(0, 2) == 0);
         halt_MEM         = !dmem_req_MEM && ($urandom_range(0, 15) == 0);
         resume           = ($urandom_range(0, 3) == 0);
         if (m_err && $urandom_range(0, 2) == 0) begin
            #2;
            do_reset("rnd_reset");
         end else begin
            step("rnd");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
